find_max_datapath: RTL and testbench
====================================

Name: find_max_datapath

Overview:
Datapath for the findMax circuit, directly downstream of the FSM controller. When enabled, it scans a DEPTH-entry synchronous-read BRAM and tracks the largest unsigned word and its address. It returns a done level, which the top level wires to the controller's ActiveDoneSignal input. Results are held stable while done is high.

Parameters:
DATA_W, 8, width of each memory word and of max_value
ADDR_W, 4, memory address width
DEPTH, 16, number of words scanned (addresses 0..DEPTH-1); must satisfy 2 <= DEPTH <= 2**ADDR_W

Ports:
clka  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
active  input  1  level enable from controller (ActiveDapapath); 1 = run or hold result, 0 = abort/idle
mem_dout  input  DATA_W  BRAM read data; valid one cycle after address presented
mem_en  output  1  BRAM read enable
mem_addr  output  ADDR_W  BRAM read address (registered)
max_value  output  DATA_W  largest word found so far
max_index  output  ADDR_W  address of max_value
busy  output  1  high in FETCH and SCAN
done  output  1  scan complete; to controller ActiveDoneSignal

Behaviour:
- Reset (reset=0, async): state=IDLE; mem_en=0, mem_addr=0, max_value=0, max_index=0, busy=0, done=0. Applies immediately, including mid-scan.
- All outputs are registered. Compare is unsigned.
- Read timing: an address driven with mem_en=1 in cycle n yields mem_dout, sampled at the end of cycle n+1.
- States: IDLE, FETCH, SCAN, DONE.
- IDLE:
  - mem_en=0, done=0.
  - On active=1: go to FETCH; mem_addr<=0, mem_en<=1, max_value<=0, max_index<=0, rd_idx<=0.
- FETCH (1 cycle):
  - Data for addr 0 is pending.
  - mem_addr<=1, mem_en stays 1; go to SCAN.
- SCAN (one word per cycle):
  - mem_dout belongs to rd_idx.
  - If rd_idx==0, or mem_dout > max_value (strict), load max_value<=mem_dout and max_index<=rd_idx.
  - Ties keep the lowest index.
  - rd_idx increments each cycle.
  - mem_addr increments while mem_addr < DEPTH-1; it holds at DEPTH-1 with mem_en<=0 once the last address has been issued.
  - When rd_idx==DEPTH-1 (last compare this cycle): go to DONE.
- DONE:
  - done=1, busy=0, mem_en=0.
  - max_value and max_index are frozen.
  - Stays in DONE while active=1.
  - On active=0: go to IDLE, done<=0. max_value and max_index hold until the next start.
- Latency: done rises DEPTH+2 rising edges after the edge that samples active=1 in IDLE (18 for default).
- Abort: active=0 in FETCH or SCAN causes IDLE on the next edge. mem_en<=0, done stays 0, and partial max_value/max_index are retained but not meaningful.
- Restart: requires active to go low (IDLE) and then high again. A new scan always clears the result registers first.
- active=1 held continuously never causes a second scan.
- rd_idx and mem_addr never wrap. Counters are ADDR_W+1 bits internally, so DEPTH=2**ADDR_W terminates correctly.

Decomposition:
- Shared package/header holds:
  - state encodings S_IDLE=0, S_FETCH=1, S_SCAN=2, S_DONE=3 (2-bit)
  - default DATA_W/ADDR_W/DEPTH
- One sub-module, max_compare_reg: holds the max_value/max_index registers with the load rule (first | strict greater), plus a clear input.
- Sequencing and address generation stay in find_max_datapath.

Test Plan:
- Memory = 3,9,1,9,0,...,0 (DEPTH=16); active 0->1 -> max_value=9, max_index=1 (tie keeps lowest); done rises exactly 18 edges after active sampled.
- Memory all 0x00 -> max_value=0, max_index=0, done=1. Memory with 0xFF only at addr 15 -> max_value=0xFF, max_index=15 (last-element and full-range compare).
- Hold active=1 for 40 cycles after done -> done stays 1; mem_en stays 0; results unchanged; no second scan. Then drop active -> done=0 next edge.
- Drop active at SCAN rd_idx=5 -> IDLE next edge, mem_en=0, done never asserts. Re-raise active -> full scan, correct result, max regs cleared first.
- Assert reset=0 asynchronously mid-SCAN (between edges) -> all outputs 0 immediately. Release with active=1 -> new scan starts from addr 0.
- Parameter run DATA_W=4, ADDR_W=3, DEPTH=8 -> counters terminate without wrap; done after 10 edges; index of max correct.

Source files
------------

// File: rtl/find_max_datapath_pkg.sv
// rtl/find_max_datapath_pkg.sv - shared state encoding and default sizes for the findMax datapath
// Contents: state_e (S_IDLE/S_FETCH/S_SCAN/S_DONE) and the default DATA_W/ADDR_W/DEPTH.
package find_max_datapath_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/find_max_datapath_max_compare_reg.sv
// rtl/find_max_datapath_max_compare_reg.sv - running-maximum value/index register pair
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         zero both registers (start of a new scan)
//   cmp_en_i        a valid word is presented on data_i this cycle
//   first_i         data_i is the first word of the scan; load unconditionally
//   data_i, index_i candidate word and its address
//   max_value_o, max_index_o  current maximum and its address
module max_compare_reg
    import find_max_datapath_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              cmp_en_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] index_i,
    output logic [DATA_W-1:0] max_value_o,
    output logic [ADDR_W-1:0] max_index_o
);

    logic [DATA_W-1:0] value_q;
    logic [ADDR_W-1:0] index_q;
    logic              load;

    // Strict greater-than: an equal later word never displaces the earlier index.
    assign load = cmp_en_i && (first_i || (data_i > value_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
            index_q <= '0;
        end else if (clear_i) begin
            value_q <= '0;
            index_q <= '0;
        end else if (load) begin
            value_q <= data_i;
            index_q <= index_i;
        end
    end

    assign max_value_o = value_q;
    assign max_index_o = index_q;

endmodule

// File: rtl/find_max_datapath.sv
// rtl/find_max_datapath.sv - scans a synchronous-read BRAM and reports the largest word and its address
// Ports:
//   clka      clock
//   reset     asynchronous active-low reset
//   active    run/hold level from the controller; low aborts or returns to idle
//   mem_dout  BRAM read data, one cycle after the address
//   mem_en    BRAM read enable
//   mem_addr  BRAM read address
//   max_value largest word found
//   max_index address of max_value
//   busy      high while fetching/scanning
//   done      scan complete, held until active drops
module find_max_datapath
    import find_max_datapath_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              active,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] max_value,
    output logic [ADDR_W-1:0] max_index,
    output logic              busy,
    output logic              done
);

    // One extra bit so that DEPTH == 2**ADDR_W still has a representable last index.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
    logic             mem_en_q, mem_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             clear;
    logic             cmp_en;

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rd_idx_q <= '0;
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_idx_q <= rd_idx_d;
            mem_en_q <= mem_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_idx_d = rd_idx_q;
        mem_en_d = mem_en_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE: begin
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b0;
                if (active) begin
                    state_d  = S_FETCH;
                    addr_d   = '0;
                    rd_idx_d = '0;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_FETCH: begin
                if (!active) begin
                    state_d  = S_IDLE;
                    mem_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    // Word 0 is in flight; issue address 1 so SCAN sees one word per cycle.
                    state_d  = S_SCAN;
                    addr_d   = CNT_W'(1);
                    mem_en_d = 1'b1;
                end
            end
            S_SCAN: begin
                if (!active) begin
                    state_d  = S_IDLE;
                    mem_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (addr_q < LAST) begin
                        addr_d = addr_q + 1'b1;
                    end else begin
                        mem_en_d = 1'b0;
                    end
                    if (rd_idx_q == LAST) begin
                        state_d  = S_DONE;
                        mem_en_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                if (!active) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    assign clear  = (state_q == S_IDLE) && active;
    assign cmp_en = (state_q == S_SCAN) && active;

    max_compare_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_max (
        .clk_i       (clka),
        .rst_ni      (reset),
        .clear_i     (clear),
        .cmp_en_i    (cmp_en),
        .first_i     (rd_idx_q == '0),
        .data_i      (mem_dout),
        .index_i     (rd_idx_q[ADDR_W-1:0]),
        .max_value_o (max_value),
        .max_index_o (max_index)
    );

    assign mem_en   = mem_en_q;
    assign mem_addr = addr_q[ADDR_W-1:0];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_find_max_datapath.sv
// tb/tb_find_max_datapath.sv - randomized scoreboard bench for find_max_datapath (default and 4/3/8 builds)
module tb_find_max_datapath;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    // DUT A: DATA_W=8, ADDR_W=4, DEPTH=16
    logic       rst_a, act_a;
    logic [7:0] dout_a = '0;
    logic       en_a;
    logic [3:0] addr_a;
    logic [7:0] maxv_a;
    logic [3:0] maxi_a;
    logic       busy_a, done_a;

    // DUT B: DATA_W=4, ADDR_W=3, DEPTH=8
    logic       rst_b, act_b;
    logic [3:0] dout_b = '0;
    logic       en_b;
    logic [2:0] addr_b;
    logic [3:0] maxv_b;
    logic [2:0] maxi_b;
    logic       busy_b, done_b;

    logic [7:0] mem_a [16];
    logic [3:0] mem_b [8];

    find_max_datapath u_a (
        .clka(clka), .reset(rst_a), .active(act_a), .mem_dout(dout_a),
        .mem_en(en_a), .mem_addr(addr_a), .max_value(maxv_a), .max_index(maxi_a),
        .busy(busy_a), .done(done_a)
    );

    find_max_datapath #(.DATA_W(4), .ADDR_W(3), .DEPTH(8)) u_b (
        .clka(clka), .reset(rst_b), .active(act_b), .mem_dout(dout_b),
        .mem_en(en_b), .mem_addr(addr_b), .max_value(maxv_b), .max_index(maxi_b),
        .busy(busy_b), .done(done_b)
    );

    // Synchronous-read BRAM models
    always @(posedge clka) if (en_a) dout_a <= mem_a[addr_a];
    always @(posedge clka) if (en_b) dout_b <= mem_b[addr_b];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int val;
        int idx;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference: first position of the largest unsigned word.
    function automatic exp_t ref_max(input bit s);
        exp_t r;
        int   n;
        int   w;
        r.val = -1;
        r.idx = 0;
        n = s ? 8 : 16;
        for (int i = 0; i < n; i++) begin
            w = s ? int'(mem_b[i]) : int'(mem_a[i]);
            if (w > r.val) begin
                r.val = w;
                r.idx = i;
            end
        end
        return r;
    endfunction

    function automatic int f_done(input bit s); return s ? int'(done_b) : int'(done_a); endfunction
    function automatic int f_en(input bit s);   return s ? int'(en_b)   : int'(en_a);   endfunction
    function automatic int f_busy(input bit s); return s ? int'(busy_b) : int'(busy_a); endfunction
    function automatic int f_addr(input bit s); return s ? int'(addr_b) : int'(addr_a); endfunction
    function automatic int f_val(input bit s);  return s ? int'(maxv_b) : int'(maxv_a); endfunction
    function automatic int f_idx(input bit s);  return s ? int'(maxi_b) : int'(maxi_a); endfunction

    // Monitor: compares the result each time done rises.
    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;
    exp_t me;
    always @(negedge clka) begin
        if (done_a && !done_a_prev) begin
            if (q_a.size() == 0) check("unexpected_done_a", 1, 0);
            else begin
                me = q_a.pop_front();
                check("max_value_a", maxv_a, me.val);
                check("max_index_a", maxi_a, me.idx);
            end
        end
        if (done_b && !done_b_prev) begin
            if (q_b.size() == 0) check("unexpected_done_b", 1, 0);
            else begin
                me = q_b.pop_front();
                check("max_value_b", maxv_b, me.val);
                check("max_index_b", maxi_b, me.idx);
            end
        end
        done_a_prev <= done_a;
        done_b_prev <= done_b;
    end

    // Counts edges from the one that samples active (edge 1) until done is seen.
    task automatic wait_done(input bit s, input int exp_edges, input string name);
        int n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clka); #1;
            if (i == 1) begin
                check({name, "_clr_val"}, f_val(s), 0);
                check({name, "_clr_idx"}, f_idx(s), 0);
                check({name, "_start_en"}, f_en(s), 1);
                check({name, "_start_addr"}, f_addr(s), 0);
            end
            if (f_done(s) != 0) begin
                n = i;
                break;
            end
        end
        check({name, "_latency"}, n, exp_edges);
    endtask

    task automatic run_scan(input bit s, input string name, input int hold);
        exp_t e;
        int   depth;
        int   bad;
        depth = s ? 8 : 16;
        e = ref_max(s);
        @(negedge clka);
        if (s) begin q_b.push_back(e); act_b = 1'b1; end
        else   begin q_a.push_back(e); act_a = 1'b1; end
        wait_done(s, depth + 2, name);
        check({name, "_addr_hold"}, f_addr(s), depth - 1);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clka); #1;
            if (f_done(s) != 1 || f_en(s) != 0 || f_busy(s) != 0 ||
                f_val(s) != e.val || f_idx(s) != e.idx) bad++;
        end
        check({name, "_hold_bad_cycles"}, bad, 0);
        @(negedge clka);
        if (s) act_b = 1'b0; else act_a = 1'b0;
        @(posedge clka); #1;
        check({name, "_done_drop"}, f_done(s), 0);
        check({name, "_val_kept"}, f_val(s), e.val);
        check({name, "_idx_kept"}, f_idx(s), e.idx);
    endtask

    exp_t ex;

    initial begin
        rst_a = 1'b0; act_a = 1'b0;
        rst_b = 1'b0; act_b = 1'b0;
        for (int i = 0; i < 16; i++) mem_a[i] = '0;
        for (int i = 0; i < 8; i++)  mem_b[i] = '0;
        repeat (2) @(posedge clka);
        #1;
        check("rst_en", en_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_val", maxv_a, 0);
        check("rst_idx", maxi_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        @(negedge clka);
        rst_a = 1'b1; rst_b = 1'b1;

        // Tie keeps lowest index; long hold with active high
        for (int i = 0; i < 16; i++) mem_a[i] = '0;
        mem_a[0] = 8'd3; mem_a[1] = 8'd9; mem_a[2] = 8'd1; mem_a[3] = 8'd9;
        run_scan(0, "tie", 40);

        // All zero
        for (int i = 0; i < 16; i++) mem_a[i] = '0;
        run_scan(0, "zeros", 2);

        // Full-scale value at last address
        mem_a[15] = 8'hFF;
        run_scan(0, "last_ff", 2);

        // Abort at rd_idx 5 after a large early word
        for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom_range(0, 100));
        mem_a[2] = 8'hEE;
        @(negedge clka);
        act_a = 1'b1;
        @(posedge clka);
        repeat (6) @(posedge clka);
        #1;
        check("abort_addr_at_rd5", addr_a, 6);
        check("abort_busy_at_rd5", busy_a, 1);
        @(negedge clka);
        act_a = 1'b0;
        @(posedge clka); #1;
        check("abort_en", en_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        repeat (25) @(posedge clka);
        #1;
        check("abort_done_later", done_a, 0);
        for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom_range(0, 127));
        run_scan(0, "after_abort", 1);

        // Asynchronous reset mid-scan, then restart with active held high
        @(negedge clka);
        act_a = 1'b1;
        repeat (8) @(posedge clka);
        #3;
        rst_a = 1'b0;
        #1;
        check("arst_en", en_a, 0);
        check("arst_addr", addr_a, 0);
        check("arst_val", maxv_a, 0);
        check("arst_idx", maxi_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom_range(0, 255));
        ex = ref_max(0);
        q_a.push_back(ex);
        @(negedge clka);
        rst_a = 1'b1;
        wait_done(0, 18, "arst_restart");
        @(negedge clka);
        act_a = 1'b0;
        @(posedge clka); #1;
        check("arst_restart_done_drop", done_a, 0);

        // Randomized scans
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom_range(0, 255));
            run_scan(0, "rand_a", 1);
        end

        // Small build: max at last address, ties, random
        for (int i = 0; i < 8; i++) mem_b[i] = 4'($urandom_range(0, 14));
        mem_b[7] = 4'hF;
        run_scan(1, "b_last", 3);
        for (int i = 0; i < 8; i++) mem_b[i] = 4'd5;
        mem_b[4] = 4'd12; mem_b[6] = 4'd12;
        run_scan(1, "b_tie", 1);
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) mem_b[i] = 4'($urandom_range(0, 15));
            run_scan(1, "rand_b", 1);
        end

        repeat (2) @(posedge clka);
        #1;
        check("scoreboard_drained", q_a.size() + q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
